// File: rtl/seq_shifter.sv
// Sequential barrel-free shifter: accepts one request, shifts up to STEP bits per cycle, holds result until taken.
// Optional rotate-right (op 100) is built only when SHIFTER_ROR_EN is defined.
module seq_shifter #(
  parameter int WIDTH = 16,
  parameter int STEP  = 1,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [2:0]       in_op,
  input  logic [AW-1:0]    in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err,
  output logic             busy
);

  if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("seq_shifter: WIDTH must be a power of two and at least 4");
  end
  if ((STEP < 1) || (STEP > WIDTH - 1)) begin : g_bad_step
    $error("seq_shifter: STEP must be in 1..WIDTH-1");
  end

  localparam logic [AW-1:0] STEP_A = AW'(STEP);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [WIDTH-1:0] shifted;
  logic [AW-1:0]    rem_q, rem_d;
  logic [AW-1:0]    step_amt;
  logic [2:0]       op_q, op_d;
  logic             out_valid_q, out_valid_d;
  logic             out_err_q, out_err_d;

  function automatic logic op_is_shift(input logic [2:0] op);
    case (op)
      3'b001, 3'b010, 3'b011: return 1'b1;
`ifdef SHIFTER_ROR_EN
      3'b100:                 return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

  // One shift step of s positions; s is never zero while shifting.
  function automatic logic [WIDTH-1:0] shift_step(input logic [2:0]       op,
                                                  input logic [WIDTH-1:0] val,
                                                  input logic [AW-1:0]    s);
    logic signed [WIDTH-1:0] sval;
    sval = $signed(val);
    case (op)
      3'b001:  return val << s;
      3'b010:  return val >> s;
      3'b011:  return $unsigned(sval >>> s);
`ifdef SHIFTER_ROR_EN
      3'b100:  return (val >> s) | (val << (WIDTH - int'(s)));
`endif
      default: return val;
    endcase
  endfunction

  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    rem_d       = rem_q;
    op_d        = op_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    step_amt    = (rem_q < STEP_A) ? rem_q : STEP_A;
    shifted     = shift_step(op_q, work_q, step_amt);

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d = in_data;
          op_d   = in_op;
          if (op_is_shift(in_op) && (in_amt != '0)) begin
            rem_d   = in_amt;
            state_d = SHIFT;
          end else begin
            rem_d       = '0;
            out_data_d  = in_data;
            out_err_d   = !((in_op == 3'b000) || op_is_shift(in_op));
            out_valid_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      SHIFT: begin
        work_d = shifted;
        rem_d  = rem_q - step_amt;
        if (rem_q == step_amt) begin
          out_data_d  = shifted;
          out_err_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Working operand and captured op are only meaningful after an accept.
  always_ff @(posedge clk) begin
    work_q <= work_d;
    op_q   <= op_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: WIDTH=16 with STEP=1 (main) and STEP=4 (latency) instances on shared inputs.
module tb_seq_shifter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [2:0]  in_op;
  logic [3:0]  in_amt;
  logic        out_ready;

  logic        in_ready, out_valid, out_err, busy;
  logic [15:0] out_data;
  logic        in_ready4, out_valid4, out_err4, busy4;
  logic [15:0] out_data4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_shifter #(.WIDTH(16), .STEP(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_op(in_op), .in_amt(in_amt), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_err(out_err), .busy(busy)
  );

  seq_shifter #(.WIDTH(16), .STEP(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_op(in_op), .in_amt(in_amt), .out_valid(out_valid4),
    .out_ready(out_ready), .out_data(out_data4), .out_err(out_err4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one request, measure latency, check result, then drain it.
  task automatic run_op(input string tag, input logic [15:0] d, input logic [2:0] op,
                        input logic [3:0] amt, input logic [15:0] exp_d, input logic exp_err,
                        input int exp_lat, input int exp_lat4);
    int n;
    int lat4;
    check({tag, "/ready"}, 32'(in_ready), 32'd1);
    in_data  = d;
    in_op    = op;
    in_amt   = amt;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n    = 1;
    lat4 = 0;
    if (out_valid4) lat4 = n;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (out_valid4 && lat4 == 0) lat4 = n;
    end
    check({tag, "/lat"}, 32'(n), 32'(exp_lat));
    check({tag, "/data"}, 32'(out_data), 32'(exp_d));
    check({tag, "/err"}, 32'(out_err), 32'(exp_err));
    if (exp_lat4 >= 0) begin
      check({tag, "/lat4"}, 32'(lat4), 32'(exp_lat4));
      check({tag, "/data4"}, 32'(out_data4), 32'(exp_d));
      check({tag, "/err4"}, 32'(out_err4), 32'(exp_err));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "/drain_valid"}, 32'(out_valid), 32'd0);
    check({tag, "/drain_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    int cnt;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_op     = 3'b000;
    in_amt    = 4'd0;
    out_ready = 1'b0;
    #2;
    check("rst/in_ready", 32'(in_ready), 32'd1);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/out_valid", 32'(out_valid), 32'd0);
    check("rst/out_data", 32'(out_data), 32'd0);
    check("rst/out_err", 32'(out_err), 32'd0);
    check("rst/in_ready4", 32'(in_ready4), 32'd1);
    check("rst/busy4", 32'(busy4), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    run_op("asr_neg", 16'h8004, 3'b011, 4'd2,  16'hE001, 1'b0, 3,  -1);
    run_op("lsl_15",  16'h0001, 3'b001, 4'd15, 16'h8000, 1'b0, 16, 5);
    run_op("lsr_4",   16'hF000, 3'b010, 4'd4,  16'h0F00, 1'b0, 5,  -1);
    run_op("asr_pos", 16'h4000, 3'b011, 4'd3,  16'h0800, 1'b0, 4,  -1);
    run_op("pass",    16'h1234, 3'b000, 4'd5,  16'h1234, 1'b0, 1,  1);
    run_op("illegal", 16'hABCD, 3'b111, 4'd3,  16'hABCD, 1'b1, 1,  1);
    run_op("amt0",    16'h00FF, 3'b001, 4'd0,  16'h00FF, 1'b0, 1,  1);
`ifdef SHIFTER_ROR_EN
    run_op("ror",     16'h0001, 3'b100, 4'd1,  16'h8000, 1'b0, 2,  2);
    run_op("ror_5",   16'h0013, 3'b100, 4'd5,  16'h9800, 1'b0, 6,  3);
`else
    run_op("ror_off", 16'h0001, 3'b100, 4'd1,  16'h0001, 1'b1, 1,  1);
`endif

    // Backpressure: result held, new requests ignored while busy.
    in_data  = 16'h0003;
    in_op    = 3'b001;
    in_amt   = 4'd1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("bp/valid0", 32'(out_valid), 32'd1);
    check("bp/data0", 32'(out_data), 32'h0006);
    for (int i = 0; i < 5; i++) begin
      in_data = 16'h1111 * 16'(i + 1);
      in_op   = 3'(i);
      in_amt  = 4'(i + 3);
      @(posedge clk);
      #1;
      check("bp/data", 32'(out_data), 32'h0006);
      check("bp/in_ready", 32'(in_ready), 32'd0);
      check("bp/valid", 32'(out_valid), 32'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp/release_valid", 32'(out_valid), 32'd0);
    check("bp/release_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    check("bp/no_second_accept", 32'(busy), 32'd0);

    // Reset during the third SHIFT cycle of an 8-step LSR.
    in_data  = 16'hFF00;
    in_op    = 3'b010;
    in_amt   = 4'd8;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("mid/busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid/out_valid", 32'(out_valid), 32'd0);
    check("mid/in_ready", 32'(in_ready), 32'd1);
    check("mid/busy", 32'(busy), 32'd0);
    check("mid/out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    check("mid/no_result", 32'(cnt), 32'd0);

    // First accept right after reset release.
    rst_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op("post_rst", 16'h5A5A, 3'b000, 4'd0, 16'h5A5A, 1'b0, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
